// File: rtl/fir_engine_param.sv
// FIR engine over an external synchronous memory: sequential MAC or fully pipelined per job.
// Build option FIR_PIPE_MODE_EN adds the pipelined mode (PIPE/DRAIN states, parallel products).

module fir_engine_param #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 4,
  parameter int ADDR_W = 10,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     mode,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [ADDR_W-1:0]        out_addr,
  input  logic [ADDR_W-1:0]        sample_count,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_idx,
  input  logic [COEF_W-1:0]        coef_data,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        rd_data,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              cycle_count,
  output logic [2:0]               state
);

  localparam int IW = $clog2(TAPS);
  localparam int PW = DATA_W + COEF_W;
  localparam int AW = PW + IW;
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CAPT  = 3'd2,
    S_MAC   = 3'd3,
    S_WRITE = 3'd4,
    S_PIPE  = 3'd5,
    S_DRAIN = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t state_q, state_d;

  logic signed [COEF_W-1:0] coef     [TAPS];
  logic signed [DATA_W-1:0] dline    [TAPS];
  logic signed [DATA_W-1:0] dl_shift [TAPS];
  logic signed [AW-1:0]     acc;
  logic signed [PW-1:0]     mac_prod;
  logic [IW-1:0]            tap;
  logic [ADDR_W-1:0]        in_q, out_q, cnt_q, rd_n, wr_n, last_idx;
  logic [31:0]              cyc_q;
  logic                     accept, seq_wr;
  logic                     pipe_sel, pipe_shift, s2_vld;
  logic [DATA_W-1:0]        s2_data;

  function automatic logic [DATA_W-1:0] saturate(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] s;
    s = a >>> SHIFT;
    if (s > SAT_MAX)      saturate = SAT_MAX[DATA_W-1:0];
    else if (s < SAT_MIN) saturate = SAT_MIN[DATA_W-1:0];
    else                  saturate = s[DATA_W-1:0];
  endfunction

  function automatic logic signed [PW-1:0] mul(input logic signed [COEF_W-1:0] c,
                                               input logic signed [DATA_W-1:0] d);
    mul = PW'(c) * PW'(d);
  endfunction

  // A new job can be accepted whenever busy is low, including the DONE cycle.
  assign accept   = start && (state_q == S_IDLE || state_q == S_DONE);
  assign last_idx = cnt_q - 1'b1;
  assign mac_prod = mul(coef[tap], dline[tap]);

  always_comb begin
    dl_shift[0] = $signed(rd_data);
    for (int k = 1; k < TAPS; k++) dl_shift[k] = dline[k-1];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          if (sample_count == '0) state_d = S_DONE;
          else if (pipe_sel)      state_d = S_PIPE;
          else                    state_d = S_READ;
        end
      end
      S_READ:  state_d = S_CAPT;
      S_CAPT:  state_d = S_MAC;
      S_MAC:   if (tap == IW'(TAPS-1)) state_d = S_WRITE;
      S_WRITE: state_d = (wr_n == last_idx) ? S_DONE : S_READ;
`ifdef FIR_PIPE_MODE_EN
      S_PIPE:  if (rd_n == last_idx) state_d = S_DRAIN;
      S_DRAIN: if (s2_vld && wr_n == last_idx) state_d = S_DONE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = !(state_q == S_IDLE || state_q == S_DONE);
  assign done        = (state_q == S_DONE);
  assign state       = state_q;
  assign cycle_count = cyc_q;
  assign rd_en       = (state_q == S_READ) || (state_q == S_PIPE);
  assign rd_addr     = rd_en ? in_q + rd_n : '0;
  assign seq_wr      = (state_q == S_WRITE);
  assign wr_en       = seq_wr || s2_vld;
  assign wr_addr     = wr_en ? out_q + wr_n : '0;
  assign wr_data     = seq_wr ? saturate(acc) : (s2_vld ? s2_data : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      in_q    <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      rd_n    <= '0;
      wr_n    <= '0;
      tap     <= '0;
      acc     <= '0;
      cyc_q   <= '0;
      for (int k = 0; k < TAPS; k++) dline[k] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        in_q  <= in_addr;
        out_q <= out_addr;
        cnt_q <= sample_count;
        rd_n  <= '0;
        wr_n  <= '0;
        cyc_q <= '0;
        for (int k = 0; k < TAPS; k++) dline[k] <= '0;
      end else begin
        if (busy)  cyc_q <= cyc_q + 32'd1;
        if (rd_en) rd_n  <= rd_n + 1'b1;
        if (wr_en) wr_n  <= wr_n + 1'b1;
        if (state_q == S_CAPT || pipe_shift)
          for (int k = 0; k < TAPS; k++) dline[k] <= dl_shift[k];
      end
      if (state_q == S_CAPT) begin
        acc <= '0;
        tap <= '0;
      end else if (state_q == S_MAC) begin
        acc <= acc + AW'(mac_prod);
        tap <= tap + 1'b1;
      end
    end
  end

  // Coefficients survive across jobs; only reset restores the identity filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef[0] <= COEF_W'(1) << SHIFT;
      for (int k = 1; k < TAPS; k++) coef[k] <= '0;
    end else if (coef_we && !busy && (int'(coef_idx) < TAPS)) begin
      coef[coef_idx] <= coef_data;
    end
  end

`ifdef FIR_PIPE_MODE_EN
  logic                 rd_pend, s1_vld;
  logic signed [PW-1:0] prod_q [TAPS];
  logic signed [AW-1:0] prod_sum;

  always_comb begin
    prod_sum = '0;
    for (int k = 0; k < TAPS; k++) prod_sum = prod_sum + AW'(prod_q[k]);
  end

  // rd_en -> data returns -> stage 1 products -> stage 2 sum/saturate; write 3 cycles after read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      s2_data <= '0;
      for (int k = 0; k < TAPS; k++) prod_q[k] <= '0;
    end else begin
      rd_pend <= (state_q == S_PIPE);
      s1_vld  <= rd_pend;
      s2_vld  <= s1_vld;
      if (rd_pend)
        for (int k = 0; k < TAPS; k++) prod_q[k] <= mul(coef[k], dl_shift[k]);
      if (s1_vld) s2_data <= saturate(prod_sum);
    end
  end

  assign pipe_shift = rd_pend;
  assign pipe_sel   = mode;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign pipe_shift  = 1'b0;
  assign pipe_sel    = 1'b0;
  assign s2_vld      = 1'b0;
  assign s2_data     = '0;
`endif

endmodule

// File: tb/tb_fir_engine_param.sv
// Self-checking bench for fir_engine_param: random jobs against a plain-arithmetic FIR model,
// with a write scoreboard fed at job issue and drained by a monitor on every wr_en.

module tb_fir_engine_param;

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int TAPS   = 4;
  localparam int ADDR_W = 10;
  localparam int SHIFT  = 0;
  localparam int IW     = $clog2(TAPS);
  localparam int EW     = ADDR_W + DATA_W;
`ifdef FIR_PIPE_MODE_EN
  localparam bit PIPE_EN = 1'b1;
`else
  localparam bit PIPE_EN = 1'b0;
`endif

  logic              clk, rst_n, start, mode, coef_we;
  logic [ADDR_W-1:0] in_addr, out_addr, sample_count;
  logic [IW-1:0]     coef_idx;
  logic [COEF_W-1:0] coef_data;
  logic              rd_en, wr_en, busy, done;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [DATA_W-1:0] rd_data, wr_data;
  logic [31:0]       cycle_count;
  logic [2:0]        state;

  fir_engine_param #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .ADDR_W(ADDR_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .in_addr(in_addr), .out_addr(out_addr),
    .sample_count(sample_count), .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .cycle_count(cycle_count), .state(state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared state ----------------
  logic [DATA_W-1:0] mem [1<<ADDR_W];
  logic [EW-1:0]     exp_q[$];
  int                rd_t_q[$];
  int                c_m[TAPS];
  int                xs[$];
  int                checks = 0, failures = 0, cyc = 0, cur_lat = 0, writes_seen = 0;
  logic              rd_req_d = 1'b0;
  logic [ADDR_W-1:0] rd_addr_d = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- memory model: data returns one cycle after rd_en ----------------
  always @(negedge clk) begin
    if (rd_req_d) rd_data = mem[rd_addr_d];
    else          rd_data = DATA_W'($urandom);
    rd_req_d  = rd_en;
    rd_addr_d = rd_addr;
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n) begin
      if (rd_en) rd_t_q.push_back(cyc);
      if (rd_en && wr_en) check("rd_wr_same_addr", rd_addr == wr_addr, 1'b0);
      if (wr_en) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", {wr_addr, wr_data}, '0 - 1);
        end else begin
          e = exp_q.pop_front();
          check("write_addr_data", {wr_addr, wr_data}, e);
          if (rd_t_q.size() == 0) check("wr_latency_noread", 0, cur_lat);
          else                    check("wr_latency", cyc - rd_t_q.pop_front(), cur_lat);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int model_y(input int i);
    longint acc = 0;
    longint maxv = (64'sd1 <<< (DATA_W-1)) - 1;
    for (int k = 0; k < TAPS; k++)
      if (i - k >= 0) acc += longint'(c_m[k]) * longint'(xs[i-k]);
    acc = acc >>> SHIFT;
    if (acc > maxv) acc = maxv;
    if (acc < -maxv - 1) acc = -maxv - 1;
    return int'(acc);
  endfunction

  function automatic void model_reset();
    c_m[0] = 1 << SHIFT;
    for (int k = 1; k < TAPS; k++) c_m[k] = 0;
  endfunction

  function automatic void push_expected(input int oa);
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < xs.size(); i++) begin
      a = ADDR_W'(oa + i);
      exp_q.push_back({a, DATA_W'(model_y(i))});
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic set_coef(input int idx, input int val);
    @(negedge clk);
    coef_we = 1'b1; coef_idx = IW'(idx); coef_data = COEF_W'(val);
    @(negedge clk);
    coef_we = 1'b0;
    c_m[idx] = val;
  endtask

  task automatic load_mem(input int ia);
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < xs.size(); i++) begin
      a = ADDR_W'(ia + i);
      mem[a] = DATA_W'(xs[i]);
    end
  endtask

  task automatic run_job(input bit m, input int ia, input int oa, input bit disturb,
                         input bit co_we, input int co_idx, input int co_val);
    int n, exp_busy, elapsed, bound;
    bit pe;
    n = xs.size();
    load_mem(ia);
    if (co_we) c_m[co_idx] = co_val;
    push_expected(oa);
    pe       = m && PIPE_EN;
    exp_busy = (n == 0) ? 0 : (pe ? n + 3 : n * (TAPS + 3));
    cur_lat  = pe ? 3 : TAPS + 2;
    bound    = exp_busy + 20;
    @(negedge clk);
    start = 1'b1; mode = m; in_addr = ADDR_W'(ia); out_addr = ADDR_W'(oa);
    sample_count = ADDR_W'(n);
    coef_we = co_we; coef_idx = IW'(co_idx); coef_data = COEF_W'(co_val);
    @(negedge clk);
    start = 1'b0; coef_we = 1'b0;
    elapsed = 1;
    while (!done && elapsed < bound) begin
      if (disturb && elapsed == 3) begin
        start = 1'b1; in_addr = ADDR_W'(ia + 5); sample_count = ADDR_W'(1);
        coef_we = 1'b1; coef_idx = '0; coef_data = COEF_W'(77);
      end else begin
        start = 1'b0; coef_we = 1'b0;
      end
      @(negedge clk);
      elapsed++;
    end
    start = 1'b0; coef_we = 1'b0;
    check("done_seen", done, 1'b1);
    check("done_time", elapsed, exp_busy + 1);
    check("cycle_count", cycle_count, exp_busy);
    check("busy_at_done", busy, 1'b0);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("idle_after_done", state, 3'd0);
    check("writes_complete", exp_q.size(), 0);
    exp_q.delete();
    rd_t_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {rd_en, wr_en, busy, done, state}, '0);
    check({tag, "_data"}, {rd_addr, wr_addr, wr_data, cycle_count}, '0);
  endtask

  function automatic int rnd_s8();
    int v;
    v = int'($urandom_range(0, 255));
    return v - 128;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int w0, waited, ia;
    bit m;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; coef_we = 1'b0; coef_idx = '0; coef_data = '0;
    in_addr = '0; out_addr = '0; sample_count = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    // identity filter after reset, sequential
    xs = '{5, -3, 127};
    run_job(1'b0, 0, 512, 1'b0, 1'b0, 0, 0);

    // moving sum, pipelined
    for (int k = 0; k < TAPS; k++) set_coef(k, 1);
    xs = '{10, 20, 30, 40, 50};
    run_job(1'b1, 100, 600, 1'b0, 1'b0, 0, 0);

    // saturation in both modes
    for (int k = 0; k < TAPS; k++) set_coef(k, 127);
    xs = '{127, -128};
    run_job(1'b0, 300, 800, 1'b0, 1'b0, 0, 0);
    run_job(1'b1, 300, 820, 1'b0, 1'b0, 0, 0);

    // address wrap-around in both modes
    set_coef(0, 3); set_coef(1, -2); set_coef(2, 1); set_coef(3, 1);
    xs = '{rnd_s8(), rnd_s8(), rnd_s8()};
    run_job(1'b0, 1022, 1023, 1'b0, 1'b0, 0, 0);
    run_job(1'b1, 1022, 1023, 1'b0, 1'b0, 0, 0);

    // empty job
    xs.delete();
    run_job(1'b0, 40, 900, 1'b0, 1'b0, 0, 0);

    // start and coef_we mid-job are ignored
    xs = '{rnd_s8(), rnd_s8(), rnd_s8(), rnd_s8()};
    run_job(1'b0, 50, 700, 1'b1, 1'b0, 0, 0);

    // coefficient write together with start is used by that job
    xs = '{rnd_s8(), rnd_s8(), rnd_s8(), rnd_s8(), rnd_s8()};
    run_job(1'b1, 60, 710, 1'b0, 1'b1, 1, -45);

    // randomized jobs
    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < TAPS; k++) set_coef(k, rnd_s8());
      xs.delete();
      for (int i = 0; i < int'($urandom_range(1, 10)); i++) xs.push_back(rnd_s8());
      ia = int'($urandom_range(0, 1023));
      m  = 1'($urandom_range(0, 1));
      run_job(m, ia, ia + 512, 1'b0, 1'b0, 0, 0);
    end

    // reset during the MAC phase of the second sample
    xs = '{rnd_s8(), rnd_s8(), rnd_s8()};
    load_mem(200);
    push_expected(700);
    cur_lat = TAPS + 2;
    w0 = writes_seen;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; in_addr = ADDR_W'(200); out_addr = ADDR_W'(700);
    sample_count = ADDR_W'(3);
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (!(state == 3'd3 && writes_seen == w0 + 1) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("reached_mac_sample2", waited < 100, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    exp_q.delete();
    rd_t_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // restarted job: identity restored, then a fresh filter with cleared history
    xs = '{rnd_s8(), rnd_s8(), rnd_s8()};
    run_job(1'b0, 210, 720, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < TAPS; k++) set_coef(k, 1);
    xs = '{rnd_s8(), rnd_s8(), rnd_s8(), rnd_s8()};
    run_job(1'b1, 220, 730, 1'b0, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
